// File: rtl/instr_sequencer_pkg.sv
// ============================================================================
// Module : instr_sequencer_pkg
// Brief  : Shared types for the EnDMe sequencer: opcodes, phases and classes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package instr_sequencer_pkg;

    typedef enum logic [3:0] {
        STORE = 4'h0, PUT = 4'h1, ADD = 4'h2, SUB = 4'h3,
        AND   = 4'h4, XOR = 4'h5, SFL = 4'h6, SFR = 4'h7,
        CMP   = 4'h8, GTR = 4'h9, LB  = 4'hA, SB  = 4'hB,
        BTR   = 4'hC, JMP = 4'hD
    } Instr_O;

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_NOP  = 4'hE;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALTED = 3'd6
    } Seq_State;

    typedef enum logic [2:0] {
        M   = 3'd0,
        LD  = 3'd1,
        ST  = 3'd2,
        BR  = 3'd3,
        ALU = 3'd4,
        NOP = 3'd5,
        HLT = 3'd6
    } Instr_Class;

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_if.sv
// ============================================================================
// Module : instr_sequencer_if
// Brief  : IR, memory-handshake and control-strobe bundle of the sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface instr_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             typ;
    logic [3:0]       op;
    logic             br_flag;
    logic             imem_ready;
    logic             dmem_ready;
    logic             ir_load;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             wb_en;
    logic             pc_en;
    logic             pc_br_sel;
    logic             busy;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] retired;

    modport master (
        output start, typ, op, br_flag, imem_ready, dmem_ready,
        input  ir_load, imem_req, dmem_req, dmem_we, wb_en, pc_en,
               pc_br_sel, busy, halted, err, retired
    );

    modport slave (
        input  start, typ, op, br_flag, imem_ready, dmem_ready,
        output ir_load, imem_req, dmem_req, dmem_we, wb_en, pc_en,
               pc_br_sel, busy, halted, err, retired
    );
endinterface

`default_nettype wire

// File: rtl/instr_sequencer_classifier.sv
// ============================================================================
// Module : instr_classifier
// Brief  : Combinational (typ, op) to instruction-class decode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_classifier
    import instr_sequencer_pkg::*;
(
    input  wire logic       i_typ,
    input  wire logic [3:0] i_op,
    output Instr_Class      o_cls
);

    always_comb begin
        o_cls = ALU;
        if (i_typ) begin
            o_cls = M;
        end else begin
            case (i_op)
                LB:       o_cls = LD;
                SB:       o_cls = ST;
                BTR, JMP: o_cls = BR;
                OP_NOP:   o_cls = NOP;
                OP_HALT:  o_cls = HLT;
                default:  o_cls = ALU;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// Module : instr_sequencer
// Brief  : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with ready handshakes.
//          Optional memory-wait timeout when SEQ_WAIT_TIMEOUT_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int WAIT_LIMIT = 16
) (
    input  wire logic         CLK,
    input  wire logic         reset,
    instr_sequencer_if.slave  bus
);

    Seq_State         r_state;
    Seq_State         w_next;
    Instr_Class       w_cls;
    Instr_Class       r_cls;
    logic             r_is_jmp;
    logic             r_is_btr;
    logic             w_retire;
    logic             w_timeout;
    logic [CNT_W-1:0] r_retired;

    instr_classifier u_classifier (
        .i_typ (bus.typ),
        .i_op  (bus.op),
        .o_cls (w_cls)
    );

`ifdef SEQ_WAIT_TIMEOUT_EN
    localparam int c_wait_w = $clog2(WAIT_LIMIT + 1);

    logic [c_wait_w-1:0] r_wait;
    logic                r_err;
    logic                w_waiting;

    // Leaving a wait state clears the counter, so each FETCH/MEM entry starts at zero.
    assign w_waiting = ((r_state == FETCH) && !bus.imem_ready) ||
                       ((r_state == MEM)   && !bus.dmem_ready);
    assign w_timeout = w_waiting && (r_wait == c_wait_w'(WAIT_LIMIT - 1));
    assign bus.err   = r_err;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            r_wait <= w_waiting ? r_wait + c_wait_w'(1) : '0;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign bus.err   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cls     <= ALU;
            r_is_jmp  <= 1'b0;
            r_is_btr  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) begin
                r_cls    <= w_cls;
                r_is_jmp <= (bus.op == JMP);
                r_is_btr <= (bus.op == BTR);
            end
            if (w_retire && (r_retired != '1)) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        w_retire      = 1'b0;
        bus.ir_load   = 1'b0;
        bus.imem_req  = 1'b0;
        bus.dmem_req  = 1'b0;
        bus.dmem_we   = 1'b0;
        bus.wb_en     = 1'b0;
        bus.pc_en     = 1'b0;
        bus.pc_br_sel = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ready) begin
                    bus.ir_load = 1'b1;
                    w_next      = DECODE;
                end else if (w_timeout) begin
                    w_next = HALTED;
                end
            end
            DECODE: begin
                case (w_cls)
                    M:       w_next = WB;
                    LD, ST:  w_next = MEM;
                    HLT:     w_next = HALTED;
                    default: w_next = EXEC;
                endcase
            end
            EXEC: begin
                case (r_cls)
                    ALU: w_next = WB;
                    BR: begin
                        bus.pc_en     = 1'b1;
                        bus.pc_br_sel = r_is_jmp || (r_is_btr && bus.br_flag);
                        w_retire      = 1'b1;
                        w_next        = FETCH;
                    end
                    default: begin
                        bus.pc_en = 1'b1;
                        w_retire  = 1'b1;
                        w_next    = FETCH;
                    end
                endcase
            end
            MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (r_cls == ST);
                if (bus.dmem_ready) begin
                    if (r_cls == ST) begin
                        bus.pc_en = 1'b1;
                        w_retire  = 1'b1;
                        w_next    = FETCH;
                    end else begin
                        w_next = WB;
                    end
                end else if (w_timeout) begin
                    w_next = HALTED;
                end
            end
            WB: begin
                bus.wb_en = 1'b1;
                bus.pc_en = 1'b1;
                w_retire  = 1'b1;
                w_next    = FETCH;
            end
            HALTED:  w_next = HALTED;
            default: w_next = IDLE;
        endcase
    end

    assign bus.busy    = (r_state != IDLE) && (r_state != HALTED);
    assign bus.halted  = (r_state == HALTED);
    assign bus.retired = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// Module : tb_instr_sequencer
// Brief  : Randomized scoreboard bench for instr_sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_sequencer;

    localparam int CNT_W      = 4;
    localparam int WAIT_LIMIT = 4;
    localparam int K_RET      = 0;
    localparam int K_HALT     = 1;
    localparam int RET_MAX    = (1 << CNT_W) - 1;

    typedef struct {
        int kind;
        int lat;
        int ret;
        bit wb;
        bit br;
        bit we;
        bit err;
    } exp_t;

    logic CLK;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   model_ret = 0;
    exp_t q[$];

    instr_sequencer_if #(.CNT_W(CNT_W)) bus ();

    instr_sequencer #(.CNT_W(CNT_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: cycles from first FETCH to next FETCH follow the phase count of each class.
    function automatic exp_t model(input bit t, input bit [3:0] o, input bit bf,
                                   input int wi, input int wd);
        exp_t e;
        e = '{kind: K_RET, lat: 0, ret: 0, wb: 0, br: 0, we: 0, err: 0};
        if (t) begin
            e.lat = 3; e.wb = 1;
        end else begin
            case (o)
                4'hA:    begin e.lat = 4 + wd; e.wb = 1; end
                4'hB:    begin e.lat = 3 + wd; e.we = 1; end
                4'hC:    begin e.lat = 3; e.br = bf; end
                4'hD:    begin e.lat = 3; e.br = 1; end
                4'hE:    e.lat = 3;
                4'hF:    begin e.lat = 2; e.kind = K_HALT; end
                default: begin e.lat = 4; e.wb = 1; end
            endcase
        end
        e.lat = e.lat + wi;
        return e;
    endfunction

    task automatic run_instr(input bit t, input bit [3:0] o, input bit bf,
                             input int wi, input int wd);
        exp_t e;
        int   w;
        bit   ok;
        e = model(t, o, bf, wi, wd);
        if (e.kind == K_RET) begin
            model_ret = (model_ret == RET_MAX) ? RET_MAX : model_ret + 1;
            e.ret = model_ret;
        end
        q.push_back(e);
        bus.typ = t; bus.op = o; bus.br_flag = bf;
        w = 0; ok = 0;
        for (int k = 0; k < 64; k++) begin
            if (bus.imem_req) begin
                if (w == wi) begin bus.imem_ready = 1'b1; ok = 1; break; end
                bus.imem_ready = 1'b0; w++;
            end
            @(posedge CLK); #1;
        end
        if (!ok) chk("imem_req_bound", 0, 1);
        @(posedge CLK); #1;
        bus.imem_ready = 1'b0;
        if (!t && (o == 4'hA || o == 4'hB)) begin
            w = 0; ok = 0;
            for (int k = 0; k < 64; k++) begin
                if (bus.dmem_req) begin
                    if (w == wd) begin bus.dmem_ready = 1'b1; ok = 1; break; end
                    bus.dmem_ready = 1'b0; w++;
                end else begin
                    bus.dmem_ready = 1'($urandom_range(1));
                end
                @(posedge CLK); #1;
            end
            if (!ok) chk("dmem_req_bound", 0, 1);
            @(posedge CLK); #1;
            bus.dmem_ready = 1'b0;
        end
        if (e.kind == K_HALT) return;
        ok = 0;
        for (int k = 0; k < 16; k++) begin
            if (bus.imem_req) begin ok = 1; break; end
            @(posedge CLK); #1;
        end
        if (!ok) chk("next_fetch_bound", 0, 1);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_ctrl"}, int'({bus.ir_load, bus.imem_req, bus.dmem_req, bus.dmem_we,
                                bus.wb_en, bus.pc_en, bus.pc_br_sel, bus.busy,
                                bus.halted, bus.err}), 0);
        chk({nm, "_retired"}, int'(bus.retired), 0);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
    endtask

    // Monitor: pops one expectation per retire strobe or halt entry.
    int   cycle = 0;
    int   cyc0 = 0;
    bit   prev_req = 0, prev_halt = 0, saw_we = 0, pend = 0;
    int   pend_val = 0;
    always @(negedge CLK) begin
        exp_t e;
        cycle++;
        if (reset) begin
            prev_req = 0; prev_halt = 0; pend = 0;
        end else begin
            if (pend) begin chk("retired", int'(bus.retired), pend_val); pend = 0; end
            if (bus.imem_req && !prev_req) begin cyc0 = cycle; saw_we = 0; end
            if (bus.dmem_we) saw_we = 1;
            if (bus.pc_en) begin
                if (q.size() == 0) chk("unexpected_pc_en", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("retire_kind", K_RET, e.kind);
                    chk("latency", cycle - cyc0 + 1, e.lat);
                    chk("wb_en", int'(bus.wb_en), int'(e.wb));
                    chk("pc_br_sel", int'(bus.pc_br_sel), int'(e.br));
                    chk("dmem_we", int'(saw_we), int'(e.we));
                    pend = 1; pend_val = e.ret;
                end
            end
            if (bus.halted && !prev_halt) begin
                if (q.size() == 0) chk("unexpected_halt", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("halt_kind", K_HALT, e.kind);
                    chk("halt_latency", cycle - cyc0, e.lat);
                    chk("halt_err", int'(bus.err), int'(e.err));
                    chk("halt_busy", int'(bus.busy), 0);
                end
            end
            prev_req = bus.imem_req; prev_halt = bus.halted;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        exp_t e;
        reset = 1'b1;
        bus.start = 0; bus.typ = 0; bus.op = 0; bus.br_flag = 0;
        bus.imem_ready = 0; bus.dmem_ready = 0;
        repeat (2) @(posedge CLK);
        #1;
        check_idle("reset");
        reset = 1'b0;
        @(posedge CLK); #1;
        check_idle("idle");
        pulse_start();

        run_instr(1'b0, 4'h2, 1'b0, 0, 0);
        run_instr(1'b0, 4'hD, 1'b0, 0, 0);
        run_instr(1'b0, 4'hC, 1'b0, 0, 0);
        run_instr(1'b0, 4'hB, 1'b0, 0, 3);
        run_instr(1'b0, 4'hA, 1'b0, 2, 1);
        run_instr(1'b0, 4'hE, 1'b0, 1, 0);
        for (int n = 0; n < 30; n++) begin
            run_instr(($urandom_range(3) == 0), 4'($urandom_range(14)),
                      1'($urandom_range(1)), $urandom_range(3), $urandom_range(3));
        end

        run_instr(1'b0, 4'hF, 1'b0, 1, 0);
        ok = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.halted) begin ok = 1; break; end
            @(posedge CLK); #1;
        end
        chk("halt_reached", int'(ok), 1);
        bus.start = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        bus.start = 1'b0;
        chk("start_ignored", int'({bus.halted, bus.imem_req, bus.busy}), 3'b100);
        reset = 1'b1; model_ret = 0;
        @(posedge CLK); #1;
        reset = 1'b0;
        check_idle("halt_exit");

        // Reset during an unanswered data access.
        pulse_start();
        bus.typ = 1'b0; bus.op = 4'hA;
        bus.imem_ready = 1'b1;
        @(posedge CLK); #1;
        bus.imem_ready = 1'b0;
        ok = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.dmem_req) begin ok = 1; break; end
            @(posedge CLK); #1;
        end
        chk("mem_reached", int'(ok), 1);
        repeat (2) @(posedge CLK);
        #1;
        reset = 1'b1;
        @(posedge CLK); #1;
        check_idle("mem_reset");
        reset = 1'b0;
        @(posedge CLK); #1;
        check_idle("mem_reset_after");

        pulse_start();
        bus.imem_ready = 1'b0;
`ifdef SEQ_WAIT_TIMEOUT_EN
        e = '{kind: K_HALT, lat: WAIT_LIMIT, ret: 0, wb: 0, br: 0, we: 0, err: 1};
        q.push_back(e);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.halted) begin ok = 1; break; end
            @(posedge CLK); #1;
        end
        chk("timeout_halt", int'(ok), 1);
        chk("timeout_err", int'(bus.err), 1);
        chk("timeout_retired", int'(bus.retired), 0);
`else
        e = '{kind: K_RET, lat: 0, ret: 0, wb: 0, br: 0, we: 0, err: 0};
        repeat (20) @(posedge CLK);
        #1;
        chk("fetch_hold", int'({bus.imem_req, bus.halted, bus.err, bus.busy}), 4'b1001);
`endif
        chk("queue_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
